// File: rtl/ext_other_unit.sv
// Load-data extension stage: picks the addressed byte/halfword lane of a memory
// word and sign- or zero-extends it for LB/LBU/LH/LHU, with a registered result.
package ext_other_pkg;

  typedef enum logic [1:0] {
    MODE_LB  = 2'd0,
    MODE_LBU = 2'd1,
    MODE_LH  = 2'd2,
    MODE_LHU = 2'd3
  } ext_mode_e;

endpackage

module ext_other_unit
  import ext_other_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic [1:0]  instr,
  input  logic [1:0]  addr_off,
  input  logic        in_valid,
  output logic [31:0] data_out,
  output logic        out_valid
);

  ext_mode_e   mode;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] ext_result;

  assign mode = ext_mode_e'(instr);

  // Little-endian lane select; addr_off[0] is deliberately unused for halfwords.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    byte_lane = data_in[7:0];
    unique case (addr_off)
      2'd0: byte_lane = data_in[7:0];
      2'd1: byte_lane = data_in[15:8];
      2'd2: byte_lane = data_in[23:16];
      2'd3: byte_lane = data_in[31:24];
      default: byte_lane = data_in[7:0];
    endcase
    half_lane = addr_off[1] ? data_in[31:16] : data_in[15:0];
  end

  always_comb begin
    ext_result = 32'h0000_0000;
    unique case (mode)
      MODE_LB:  ext_result = {{24{byte_lane[7]}}, byte_lane};
      MODE_LBU: ext_result = {24'h00_0000, byte_lane};
      MODE_LH:  ext_result = {{16{half_lane[15]}}, half_lane};
      MODE_LHU: ext_result = {16'h0000, half_lane};
      default:  ext_result = 32'h0000_0000;
    endcase
  end

  // Reset wins over in_valid so an in-flight load is dropped, not delivered.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out  <= 32'h0000_0000;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        data_out <= ext_result;
      end
    end
  end

endmodule

// File: tb/tb_ext_other_unit.sv
// Self-checking bench for ext_other_unit: directed vectors plus random traffic
// compared against a shift-and-mask reference of the load extension rules.
module tb_ext_other_unit;

  logic        clk;
  logic        rst;
  logic [31:0] data_in;
  logic [1:0]  instr;
  logic [1:0]  addr_off;
  logic        in_valid;
  logic [31:0] data_out;
  logic        out_valid;

  int checks;
  int errors;

  logic [31:0] exp_data;
  logic        exp_valid;

  ext_other_unit dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .instr     (instr),
    .addr_off  (addr_off),
    .in_valid  (in_valid),
    .data_out  (data_out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference: shift the lane down, mask it, then extend arithmetically.
  function automatic logic [31:0] ref_extend(input logic [31:0] d, input int mode, input int off);
    longint unsigned lane;
    longint signed   val;
    if (mode < 2) begin
      lane = (longint'(d) >> (8 * off)) & 64'hFF;
      val  = lane;
      if (mode == 0 && lane > 127) val = val - 256;
    end else begin
      lane = (longint'(d) >> (16 * (off / 2))) & 64'hFFFF;
      val  = lane;
      if (mode == 2 && lane > 32767) val = val - 65536;
    end
    return val[31:0];
  endfunction

  // Apply one cycle of inputs, clock it, advance the model and compare.
  task automatic step(input string tag, input logic r, input logic v,
                      input logic [31:0] d, input int mode, input int off);
    rst      = r;
    in_valid = v;
    data_in  = d;
    instr    = 2'(mode);
    addr_off = 2'(off);
    @(posedge clk);
    #1;
    if (r) begin
      exp_data  = 32'h0;
      exp_valid = 1'b0;
    end else begin
      exp_valid = v;
      if (v) exp_data = ref_extend(d, mode, off);
    end
    check({tag, ".data"}, data_out, exp_data);
    check({tag, ".valid"}, {31'h0, out_valid}, {31'h0, exp_valid});
  endtask

  task automatic expect_data(input string tag, input logic [31:0] exp);
    check(tag, data_out, exp);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    exp_data  = 32'h0;
    exp_valid = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    data_in   = 32'h0;
    instr     = 2'd0;
    addr_off  = 2'd0;
    @(negedge clk);

    // Reset held with valid all-ones input.
    step("rst0", 1'b1, 1'b1, 32'hFFFF_FFFF, 0, 0);
    expect_data("rst0.const", 32'h0);
    step("rst1", 1'b1, 1'b1, 32'hFFFF_FFFF, 3, 2);
    expect_data("rst1.const", 32'h0);

    // Mode sweep on consecutive cycles.
    step("sweep0", 1'b0, 1'b1, 32'h0000_A0F0, 0, 0); expect_data("sweep0.k", 32'hFFFF_FFF0);
    step("sweep1", 1'b0, 1'b1, 32'h0000_A0F0, 1, 0); expect_data("sweep1.k", 32'h0000_00F0);
    step("sweep2", 1'b0, 1'b1, 32'h0000_A0F0, 2, 0); expect_data("sweep2.k", 32'hFFFF_A0F0);
    step("sweep3", 1'b0, 1'b1, 32'h0000_A0F0, 3, 0); expect_data("sweep3.k", 32'h0000_A0F0);

    // Byte lanes.
    step("lb0", 1'b0, 1'b1, 32'h807F_01FE, 0, 0); expect_data("lb0.k", 32'hFFFF_FFFE);
    step("lb1", 1'b0, 1'b1, 32'h807F_01FE, 0, 1); expect_data("lb1.k", 32'h0000_0001);
    step("lb2", 1'b0, 1'b1, 32'h807F_01FE, 0, 2); expect_data("lb2.k", 32'h0000_007F);
    step("lb3", 1'b0, 1'b1, 32'h807F_01FE, 0, 3); expect_data("lb3.k", 32'hFFFF_FF80);
    step("lbu3", 1'b0, 1'b1, 32'h807F_01FE, 1, 3); expect_data("lbu3.k", 32'h0000_0080);

    // Halfword lanes, including the ignored addr_off[0].
    step("lh0", 1'b0, 1'b1, 32'h8001_7FFF, 2, 0); expect_data("lh0.k", 32'h0000_7FFF);
    step("lh2", 1'b0, 1'b1, 32'h8001_7FFF, 2, 2); expect_data("lh2.k", 32'hFFFF_8001);
    step("lh3", 1'b0, 1'b1, 32'h8001_7FFF, 2, 3); expect_data("lh3.k", 32'hFFFF_8001);
    step("lhu2", 1'b0, 1'b1, 32'h8001_7FFF, 3, 2); expect_data("lhu2.k", 32'h0000_8001);

    // Hold while in_valid is low.
    step("hold0", 1'b0, 1'b1, 32'h0000_00F0, 0, 0); expect_data("hold0.k", 32'hFFFF_FFF0);
    step("hold1", 1'b0, 1'b0, 32'h1234_5678, 3, 2); expect_data("hold1.k", 32'hFFFF_FFF0);
    step("hold2", 1'b0, 1'b0, 32'hDEAD_BEEF, 1, 1); expect_data("hold2.k", 32'hFFFF_FFF0);

    // Reset collides with a valid LHU; its result must never surface.
    step("coll0", 1'b1, 1'b1, 32'h0000_1234, 3, 0); expect_data("coll0.k", 32'h0);
    step("coll1", 1'b0, 1'b0, 32'h0000_1234, 3, 0); expect_data("coll1.k", 32'h0);
    step("post",  1'b0, 1'b1, 32'h0000_1234, 3, 0); expect_data("post.k", 32'h0000_1234);

    // Random traffic with occasional resets and idle cycles.
    for (int i = 0; i < 300; i++) begin
      logic r, v;
      r = ($urandom_range(0, 19) == 0);
      v = ($urandom_range(0, 3) != 0);
      step("rand", r, v, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
